// File: rtl/register_file_32x32.sv
// 32-entry register file with one write port and two registered read ports.
// R0 reads as zero; the READ/WRITE pair selects one operation per clock.
module register_file_32x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_e;

  op_e                   w_op;
  logic [NUM_REGS-1:0]   w_wr_sel;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_data_r1;
  logic [DATA_WIDTH-1:0] r_data_r2;

  always_comb begin
    w_op = OP_NOP;
    unique case ({READ, WRITE})
      2'b10:   w_op = OP_READ;
      2'b01:   w_op = OP_WRITE;
      default: w_op = OP_NOP;
    endcase
  end

  // Bit 0 of the decode is forced low so R0 never leaves its reset value.
  always_comb begin
    w_wr_sel = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      w_wr_sel[i] = (w_op == OP_WRITE) && (ADDR_W == ADDR_WIDTH'(i));
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (w_wr_sel[i]) begin
          r_regs[i] <= DATA_W;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_data_r1 <= '0;
      r_data_r2 <= '0;
    end else if (w_op == OP_READ) begin
      r_data_r1 <= r_regs[ADDR_R1];
      r_data_r2 <= r_regs[ADDR_R2];
    end
  end

  assign DATA_R1 = r_data_r1;
  assign DATA_R2 = r_data_r2;

endmodule

// File: tb/tb_register_file_32x32.sv
// Scoreboard bench for register_file_32x32: read expectations are queued at
// issue and popped by a monitor on the falling edge after the sampling edge.
module tb_register_file_32x32;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [4:0]  ADDR_R1 = '0;
  logic [4:0]  ADDR_R2 = '0;
  logic [4:0]  ADDR_W = '0;
  logic [31:0] DATA_W = '0;
  logic [31:0] DATA_R1;
  logic [31:0] DATA_R2;

  register_file_32x32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST), .READ(READ), .WRITE(WRITE),
    .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .DATA_R1(DATA_R1), .DATA_R2(DATA_R2)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        rd_v = 1'b0;
  logic [31:0] last1 = '0;
  logic [31:0] last2 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Marks the cycle whose output must reflect a sampled read.
  always @(posedge CLK or negedge RST) begin
    if (!RST) rd_v <= 1'b0;
    else      rd_v <= READ && !WRITE;
  end

  always @(negedge RST) begin
    sb.delete();
    last1 = '0;
    last2 = '0;
  end

  always @(negedge CLK) begin
    if (rd_v) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rd_p1", DATA_R1, e.e1);
        check("rd_p2", DATA_R2, e.e2);
        last1 = e.e1;
        last2 = e.e2;
      end
    end else begin
      check("hold_p1", DATA_R1, last1);
      check("hold_p2", DATA_R2, last2);
    end
  end

  task automatic op(input logic rd, input logic wr, input logic [4:0] a1, input logic [4:0] a2,
                    input logic [4:0] aw, input logic [31:0] dw,
                    input logic [31:0] e1, input logic [31:0] e2);
    READ = rd; WRITE = wr; ADDR_R1 = a1; ADDR_R2 = a2; ADDR_W = aw; DATA_W = dw;
    if (rd && !wr) sb.push_back('{e1: e1, e2: e2});
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    op(1'b0, 1'b1, 5'd0, 5'd0, a, d, '0, '0);
  endtask

  task automatic rd_pair(input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2);
    op(1'b1, 1'b0, a1, a2, 5'd0, '0, e1, e2);
  endtask

  task automatic nop(input logic [4:0] a1, input logic [4:0] a2);
    op(1'b0, 1'b0, a1, a2, 5'd0, 32'hCAFEF00D, '0, '0);
  endtask

  function automatic logic [31:0] walkv(input int i);
    return (i == 0) ? 32'h0 : 32'(i) * 32'h01010101;
  endfunction

  initial begin
    #2 RST = 1'b0;
    #1;
    check("por_p1", DATA_R1, 32'h0);
    check("por_p2", DATA_R2, 32'h0);
    #20 RST = 1'b1;
    @(posedge CLK);
    #1;

    // Walk pattern, then reads of mirrored index pairs
    for (int i = 0; i < 32; i++) wr_reg(5'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) rd_pair(5'(i), 5'(31 - i), walkv(i), walkv(31 - i));
    nop(5'd4, 5'd6);
    nop(5'd8, 5'd10);

    // R0 is hardwired zero
    wr_reg(5'd0, 32'hFFFF_FFFF);
    rd_pair(5'd0, 5'd0, 32'h0, 32'h0);

    // Both READ and WRITE high is a no-op
    rd_pair(5'd5, 5'd9, 32'h0505_0505, 32'h0909_0909);
    op(1'b1, 1'b1, 5'd1, 5'd2, 5'd5, 32'hDEAD_BEEF, '0, '0);
    nop(5'd3, 5'd4);
    rd_pair(5'd5, 5'd5, 32'h0505_0505, 32'h0505_0505);

    // Write immediately followed by read of the same index
    wr_reg(5'd7, 32'h1234_5678);
    rd_pair(5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678);
    nop(5'd1, 5'd31);
    nop(5'd2, 5'd30);

    // Extreme data values on distinct ports
    wr_reg(5'd31, 32'hFFFF_FFFF);
    wr_reg(5'd1, 32'h0000_0001);
    rd_pair(5'd31, 5'd1, 32'hFFFF_FFFF, 32'h0000_0001);
    rd_pair(5'd7, 5'd31, 32'h1234_5678, 32'hFFFF_FFFF);

    // Async reset while a write is being presented
    READ = 1'b0; WRITE = 1'b1; ADDR_W = 5'd3; DATA_W = 32'hA5A5_A5A5;
    #2 RST = 1'b0;
    #1;
    check("rst_now_p1", DATA_R1, 32'h0);
    check("rst_now_p2", DATA_R2, 32'h0);
    @(posedge CLK);
    #1;
    WRITE = 1'b0;
    #2 RST = 1'b1;
    @(posedge CLK);
    #1;
    rd_pair(5'd3, 5'd3, 32'h0, 32'h0);
    for (int i = 1; i < 32; i++) rd_pair(5'(i), 5'(32 - i), 32'h0, 32'h0);

    // Normal operation resumes after reset
    wr_reg(5'd12, 32'h0F0F_0F0F);
    rd_pair(5'd12, 5'd0, 32'h0F0F_0F0F, 32'h0);
    nop(5'd0, 5'd0);
    nop(5'd0, 5'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
